// File: rtl/com_pkg.sv
// Shared definitions for the com_* RAM front-end blocks: grant encoding and assertion helpers.
`ifndef COM_PKG_SV
`define COM_PKG_SV

`define COM_ASSERT(lbl, clk, rst_n, prop) \
    lbl: assert property (@(posedge clk) disable iff (!rst_n) (prop)) \
        else $error("com assertion lbl");

`define COM_ASSERT_NEVER(lbl, clk, rst_n, cond) \
    `COM_ASSERT(lbl, clk, rst_n, !(cond))

package com_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

endpackage

`endif

// File: rtl/com_sync_fifo_reg.sv
// Register-based synchronous FIFO: circular buffer with the head entry readable without a pop.
module com_sync_fifo_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       empty,
    output logic                       full,
    output logic [DATA_W-1:0]          head_data
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_pop;

    // Pointer increment with wrap, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (cnt_q != '0);
        wr_ptr_d = push   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign cnt       = cnt_q;
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign head_data = mem_q[rd_ptr_q];

    `COM_ASSERT_NEVER(a_fifo_push_full, clk, rst_n, push && full)

endmodule

// File: rtl/com_spram_arb.sv
// Round-robin write/read arbiter in front of the single-port RAM shell, with a
// response FIFO that absorbs read data while the consumer stalls.
module com_spram_arb
    import com_pkg::*;
#(
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned DEPTH     = 64,
    parameter  int unsigned STRB_W    = 1,
    parameter  int unsigned RSP_DEPTH = 3,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_vld,
    output logic              wr_rdy,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_vld,
    output logic              rd_rdy,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [DATA_W-1:0] rsp_data,
    output logic              ram_ce_n,
    output logic [STRB_W-1:0] ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    gnt_e              gnt;
    gnt_e              last_gnt_q, last_gnt_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_req, rd_req, rd_ok;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty, fifo_full;
    logic [DATA_W-1:0] fifo_head;

    // Credit check ignores this cycle's pop so rsp_rdy never reaches rd_rdy combinationally.
    assign rd_ok  = ((CNT_W+1)'(fifo_cnt) + (CNT_W+1)'(pend_q)) < (CNT_W+1)'(RSP_DEPTH);
    assign wr_req = wr_vld && rst_n;
    assign rd_req = rd_vld && rd_ok && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= GNT_RD;
            pend_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Grant selection and next-state for the round-robin pointer and hold registers.
    always_comb begin
        gnt        = GNT_NONE;
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (wr_req && rd_req) begin
            gnt = (last_gnt_q == GNT_WR) ? GNT_RD : GNT_WR;
        end else if (wr_req) begin
            gnt = GNT_WR;
        end else if (rd_req) begin
            gnt = GNT_RD;
        end
        if (gnt != GNT_NONE) begin
            last_gnt_d = gnt;
        end
        if (gnt == GNT_WR) begin
            addr_d  = wr_addr;
            wdata_d = wr_data;
        end else if (gnt == GNT_RD) begin
            addr_d = rd_addr;
        end
        pend_d = (gnt == GNT_RD);
    end

    // Handshakes and RAM pins; idle cycles hold address/data to avoid toggling.
    always_comb begin
        wr_rdy    = (gnt == GNT_WR);
        rd_rdy    = (gnt == GNT_RD);
        ram_ce_n  = (gnt == GNT_NONE);
        ram_we    = '0;
        ram_addr  = addr_d;
        ram_wdata = wdata_d;
        if (gnt == GNT_WR) begin
            ram_we = wr_strb;
        end
    end

    com_sync_fifo_reg #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pend_q),
        .push_data (ram_rdata),
        .pop       (rsp_vld && rsp_rdy),
        .cnt       (fifo_cnt),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .head_data (fifo_head)
    );

    assign rsp_vld  = !fifo_empty;
    assign rsp_data = fifo_head;

    `COM_ASSERT_NEVER(a_rsp_overflow, clk, rst_n, pend_q && fifo_full)

endmodule

// File: tb/tb_com_spram_arb.sv
// Self-checking bench for com_spram_arb with a behavioural RAM shell and a queue-based reference model.
module tb_com_spram_arb;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH     = 64;
    localparam int unsigned STRB_W    = 2;
    localparam int unsigned RSP_DEPTH = 3;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned LANE_W    = DATA_W / STRB_W;

    logic              clk;
    logic              rst_n;
    logic              wr_vld, wr_rdy;
    logic [ADDR_W-1:0] wr_addr;
    logic [STRB_W-1:0] wr_strb;
    logic [DATA_W-1:0] wr_data;
    logic              rd_vld, rd_rdy;
    logic [ADDR_W-1:0] rd_addr;
    logic              rsp_vld, rsp_rdy;
    logic [DATA_W-1:0] rsp_data;
    logic              ram_ce_n;
    logic [STRB_W-1:0] ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    com_spram_arb #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .STRB_W(STRB_W), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_strb(wr_strb), .wr_data(wr_data),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_addr(rd_addr),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
        .ram_ce_n(ram_ce_n), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM shell: strobed write, 1-cycle read latency, garbage data when not reading.
    logic [DATA_W-1:0] sh_mem [DEPTH];
    always @(posedge clk) begin
        if (!ram_ce_n) begin
            for (int l = 0; l < int'(STRB_W); l++) begin
                if (ram_we[l]) sh_mem[ram_addr][l*LANE_W +: LANE_W] <= ram_wdata[l*LANE_W +: LANE_W];
            end
        end
        if (!ram_ce_n && ram_we == '0) ram_rdata <= sh_mem[ram_addr];
        else                           ram_rdata <= $urandom;
    end

    // Reference model: golden memory, expected responses with the cycle they become visible.
    typedef struct {
        logic [DATA_W-1:0] data;
        int                rdy_cyc;
    } rsp_t;

    logic [DATA_W-1:0] m_mem [DEPTH];
    rsp_t              m_q[$];
    int                cyc = 0;
    bit                m_last_rd = 1'b1;
    bit                m_addr_known = 1'b0;
    logic [ADDR_W-1:0] m_last_addr;

    // 0 = no grant, 1 = write, 2 = read.
    function automatic int model_gnt();
        bit w, r;
        if (!rst_n) return 0;
        w = wr_vld;
        r = rd_vld && (m_q.size() < int'(RSP_DEPTH));
        if (w && r) return m_last_rd ? 1 : 2;
        if (w) return 1;
        if (r) return 2;
        return 0;
    endfunction

    function automatic bit model_rsp_vld();
        return (m_q.size() > 0) && (m_q[0].rdy_cyc <= cyc);
    endfunction

    function automatic logic [DATA_W-1:0] model_rsp_data();
        return (m_q.size() > 0) ? m_q[0].data : '0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_last_rd    = 1'b1;
        m_addr_known = 1'b0;
    endtask

    // Advance one clock, applying the model's own grant decision, and return at the next negedge.
    task automatic tick(input int g);
        bit pop;
        pop = model_rsp_vld() && rsp_rdy;
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (g == 1) begin
            for (int l = 0; l < int'(STRB_W); l++) begin
                if (wr_strb[l]) m_mem[wr_addr][l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
            end
            m_last_rd    = 1'b0;
            m_last_addr  = wr_addr;
            m_addr_known = 1'b1;
        end else if (g == 2) begin
            m_q.push_back('{data: m_mem[rd_addr], rdy_cyc: cyc + 2});
            m_last_rd    = 1'b1;
            m_last_addr  = rd_addr;
            m_addr_known = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input bit wv, input int wa, input logic [STRB_W-1:0] ws, input logic [DATA_W-1:0] wd,
                         input bit rv, input int ra, input bit rr);
        wr_vld  = wv;
        wr_addr = ADDR_W'(wa);
        wr_strb = ws;
        wr_data = wd;
        rd_vld  = rv;
        rd_addr = ADDR_W'(ra);
        rsp_rdy = rr;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1, 2'b11, 32'h1, 1'b1, 2, 1'b1);
        checks++; if (ram_ce_n !== 1'b1) begin errors++; $display("FAIL reset_ce_n got %b want 1", ram_ce_n); end
        checks++; if (ram_we !== '0) begin errors++; $display("FAIL reset_we got %b want 0", ram_we); end
        checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld got %b want 0", rsp_vld); end
        checks++; if (wr_rdy !== 1'b0 || rd_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b%b want 00", wr_rdy, rd_rdy); end
        tick(model_gnt());
        rst_n = 1'b1;
        drive(1'b0, 0, 2'b00, 32'h0, 1'b0, 0, 1'b1);
        tick(model_gnt());
    endtask

    // Write every address so the golden memory and the shell agree before any read.
    task automatic test_fill();
        for (int a = 0; a < int'(DEPTH); a++) begin
            drive(1'b1, a, 2'b11, $urandom, 1'b0, 0, 1'b1);
            checks++; if (wr_rdy !== 1'b1 || ram_ce_n !== 1'b0 || ram_addr !== ADDR_W'(a))
                begin errors++; $display("FAIL fill a=%0d wr_rdy=%b ce_n=%b addr=%0d want 1/0/%0d", a, wr_rdy, ram_ce_n, ram_addr, a); end
            tick(model_gnt());
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 5, 2'b11, 32'hA5A5A5A5, 1'b0, 0, 1'b1);
        checks++; if (wr_rdy !== 1'b1 || ram_ce_n !== 1'b0 || ram_we !== 2'b11 || ram_wdata !== 32'hA5A5A5A5)
            begin errors++; $display("FAIL basic_wr rdy=%b ce_n=%b we=%b wdata=%h want 1/0/11/a5a5a5a5", wr_rdy, ram_ce_n, ram_we, ram_wdata); end
        tick(model_gnt());
        drive(1'b0, 0, 2'b00, 32'h0, 1'b1, 5, 1'b1);
        checks++; if (rd_rdy !== 1'b1 || ram_ce_n !== 1'b0 || ram_we !== 2'b00 || ram_addr !== 6'd5)
            begin errors++; $display("FAIL basic_rd rdy=%b ce_n=%b we=%b addr=%0d want 1/0/00/5", rd_rdy, ram_ce_n, ram_we, ram_addr); end
        tick(model_gnt());
        drive(1'b0, 0, 2'b00, 32'h0, 1'b0, 0, 1'b1);
        checks++; if (rsp_vld !== 1'b0 || ram_ce_n !== 1'b1 || ram_addr !== 6'd5)
            begin errors++; $display("FAIL basic_lat1 rsp_vld=%b ce_n=%b addr=%0d want 0/1/5", rsp_vld, ram_ce_n, ram_addr); end
        tick(model_gnt());
        checks++; if (rsp_vld !== 1'b1 || rsp_data !== 32'hA5A5A5A5)
            begin errors++; $display("FAIL basic_rsp vld=%b data=%h want 1/a5a5a5a5", rsp_vld, rsp_data); end
        tick(model_gnt());
        checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL basic_rsp_once got %b want 0", rsp_vld); end
    endtask

    task automatic test_contention();
        int g;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 10 + i, 2'b11, $urandom, 1'b1, 20 + i, 1'b1);
            g = model_gnt();
            checks++; if (wr_rdy !== (i % 2 == 0) || rd_rdy !== (i % 2 == 1) || ram_ce_n !== 1'b0)
                begin errors++; $display("FAIL contention i=%0d wr_rdy=%b rd_rdy=%b ce_n=%b want %b/%b/0", i, wr_rdy, rd_rdy, ram_ce_n, i % 2 == 0, i % 2 == 1); end
            tick(g);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 0, 2'b00, 32'h0, 1'b0, 0, 1'b1);
            checks++; if (rsp_vld !== model_rsp_vld() || (rsp_vld && rsp_data !== model_rsp_data()))
                begin errors++; $display("FAIL contention_rsp vld=%b data=%h want %b/%h", rsp_vld, rsp_data, model_rsp_vld(), model_rsp_data()); end
            tick(model_gnt());
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int popped = 0;
        int g;
        for (int c = 0; c < 6; c++) begin
            drive(c == 4, 40, 2'b11, $urandom, 1'b1, acc, 1'b0);
            g = model_gnt();
            checks++; if (rd_rdy !== (c < 3) || wr_rdy !== (c == 4))
                begin errors++; $display("FAIL bp_stall c=%0d rd_rdy=%b wr_rdy=%b want %b/%b", c, rd_rdy, wr_rdy, c < 3, c == 4); end
            if (rd_rdy) acc++;
            tick(g);
        end
        checks++; if (acc !== 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", acc); end
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 0, 2'b00, 32'h0, c < 6, acc, 1'b1);
            g = model_gnt();
            checks++; if (rsp_vld !== model_rsp_vld() || rd_rdy !== (g == 2))
                begin errors++; $display("FAIL bp_drain c=%0d rsp_vld=%b rd_rdy=%b want %b/%b", c, rsp_vld, rd_rdy, model_rsp_vld(), g == 2); end
            if (rsp_vld && popped < 3) begin
                checks++; if (rsp_data !== m_mem[popped])
                    begin errors++; $display("FAIL bp_order k=%0d got %h want %h", popped, rsp_data, m_mem[popped]); end
                popped++;
            end
            if (rd_rdy) acc++;
            tick(g);
        end
        checks++; if (acc <= 3) begin errors++; $display("FAIL bp_resume accepted %0d want >3", acc); end
    endtask

    task automatic test_back_to_back();
        int g;
        int nrsp = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 0, 2'b00, 32'h0, i < 16, $urandom_range(0, DEPTH - 1), 1'b1);
            g = model_gnt();
            checks++; if (rd_rdy !== (i < 16))
                begin errors++; $display("FAIL b2b_rdy i=%0d got %b want %b", i, rd_rdy, i < 16); end
            checks++; if (rsp_vld !== (i >= 2 && i < 18) || (rsp_vld && rsp_data !== model_rsp_data()))
                begin errors++; $display("FAIL b2b_rsp i=%0d vld=%b data=%h want %b/%h", i, rsp_vld, rsp_data, i >= 2 && i < 18, model_rsp_data()); end
            if (rsp_vld) nrsp++;
            tick(g);
        end
        checks++; if (nrsp !== 16) begin errors++; $display("FAIL b2b_count got %0d want 16", nrsp); end
    endtask

    task automatic test_strobe();
        drive(1'b1, 7, 2'b11, 32'hFFFFFFFF, 1'b0, 0, 1'b1); tick(model_gnt());
        drive(1'b1, 7, 2'b01, 32'h00000000, 1'b0, 0, 1'b1); tick(model_gnt());
        drive(1'b1, 7, 2'b00, 32'h12345678, 1'b0, 0, 1'b1);
        checks++; if (wr_rdy !== 1'b1 || ram_ce_n !== 1'b0 || ram_we !== 2'b00)
            begin errors++; $display("FAIL strb_noop rdy=%b ce_n=%b we=%b want 1/0/00", wr_rdy, ram_ce_n, ram_we); end
        tick(model_gnt());
        drive(1'b0, 0, 2'b00, 32'h0, 1'b1, 7, 1'b1); tick(model_gnt());
        drive(1'b0, 0, 2'b00, 32'h0, 1'b0, 0, 1'b1); tick(model_gnt());
        checks++; if (rsp_vld !== 1'b1 || rsp_data !== 32'hFFFF0000)
            begin errors++; $display("FAIL strb_rsp vld=%b data=%h want 1/ffff0000", rsp_vld, rsp_data); end
        tick(model_gnt());
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 0, 2'b00, 32'h0, 1'b1, 3, 1'b1);
        checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_hs got %b want 1", rd_rdy); end
        tick(model_gnt());
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 9, 2'b11, $urandom, 1'b1, 3, 1'b1);
            checks++; if (ram_ce_n !== 1'b1 || rsp_vld !== 1'b0 || wr_rdy !== 1'b0 || rd_rdy !== 1'b0)
                begin errors++; $display("FAIL rstmid_hold i=%0d ce_n=%b rsp_vld=%b rdy=%b%b want 1/0/00", i, ram_ce_n, rsp_vld, wr_rdy, rd_rdy); end
            tick(model_gnt());
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 0, 2'b00, 32'h0, 1'b0, 0, 1'b1);
            checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL rstmid_stale i=%0d got %b want 0", i, rsp_vld); end
            tick(model_gnt());
        end
        drive(1'b0, 0, 2'b00, 32'h0, 1'b1, 3, 1'b1);
        checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_fresh_hs got %b want 1", rd_rdy); end
        tick(model_gnt());
        drive(1'b0, 0, 2'b00, 32'h0, 1'b0, 0, 1'b1); tick(model_gnt());
        checks++; if (rsp_vld !== 1'b1 || rsp_data !== m_mem[3])
            begin errors++; $display("FAIL rstmid_fresh_rsp vld=%b data=%h want 1/%h", rsp_vld, rsp_data, m_mem[3]); end
        tick(model_gnt());
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 50, $urandom_range(0, DEPTH - 1), STRB_W'($urandom), $urandom,
                  $urandom_range(0, 99) < 60, $urandom_range(0, DEPTH - 1), $urandom_range(0, 99) < 60);
            g = model_gnt();
            checks++; if (wr_rdy !== (g == 1) || rd_rdy !== (g == 2) || ram_ce_n !== (g == 0))
                begin errors++; $display("FAIL rand_gnt i=%0d wr_rdy=%b rd_rdy=%b ce_n=%b want gnt %0d", i, wr_rdy, rd_rdy, ram_ce_n, g); end
            if (g == 1) begin
                checks++; if (ram_addr !== wr_addr || ram_we !== wr_strb || ram_wdata !== wr_data)
                    begin errors++; $display("FAIL rand_wr i=%0d addr=%0d we=%b wdata=%h want %0d/%b/%h", i, ram_addr, ram_we, ram_wdata, wr_addr, wr_strb, wr_data); end
            end else if (g == 2) begin
                checks++; if (ram_addr !== rd_addr || ram_we !== '0)
                    begin errors++; $display("FAIL rand_rd i=%0d addr=%0d we=%b want %0d/00", i, ram_addr, ram_we, rd_addr); end
            end else if (m_addr_known) begin
                checks++; if (ram_addr !== m_last_addr || ram_we !== '0)
                    begin errors++; $display("FAIL rand_idle i=%0d addr=%0d we=%b want %0d/00", i, ram_addr, ram_we, m_last_addr); end
            end
            checks++; if (rsp_vld !== model_rsp_vld() || (rsp_vld && rsp_data !== model_rsp_data()))
                begin errors++; $display("FAIL rand_rsp i=%0d vld=%b data=%h want %b/%h", i, rsp_vld, rsp_data, model_rsp_vld(), model_rsp_data()); end
            tick(g);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 0, 2'b00, 32'h0, 1'b0, 0, 1'b1);
        @(negedge clk);
        test_reset();
        test_fill();
        test_basic();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_strobe();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
